// File: rtl/dmem_port_arbiter.sv
// Data memory port arbiter: MEM stage (A) has priority, loader/debug (B)
// gets a forced slot after waiting too long, stalling the pipeline once.
module dmem_port_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   a_req,
   input  logic                   a_we,
   input  logic [11:0]            a_addr,
   input  logic [31:0]            a_wdata,
   output logic                   a_stall,
   output logic [31:0]            a_rdata,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic                   b_we,
   input  logic [11:0]            b_addr,
   input  logic [31:0]            b_wdata,
   output logic                   b_rvalid,
   output logic [31:0]            b_rdata,
   output logic [11:0]            mem_addr,
   output logic                   mem_we,
   output logic [31:0]            mem_wdata,
   input  logic [31:0]            mem_rdata,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;
   logic          force_b;
   logic          grant_b;
   logic          rd_pending;
   logic [31:0]   held_rdata;

   always_comb begin
      force_b   = (STARVE_LIMIT != 0) && (starve_cnt >= LIM);
      grant_b   = !rst && b_valid && (!a_req || force_b);
      b_ready   = grant_b;
      a_stall   = a_req && grant_b;
      mem_addr  = grant_b ? b_addr  : a_addr;
      mem_wdata = grant_b ? b_wdata : a_wdata;
      mem_we    = grant_b ? b_we    : (!rst && a_req && a_we);
      a_rdata   = mem_rdata;
      // a read accepted just before reset must not surface a response
      b_rvalid  = rd_pending && !rst;
      b_rdata   = b_rvalid ? mem_rdata : held_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt  <= '0;
         rd_pending  <= 1'b0;
         held_rdata  <= '0;
         stall_count <= '0;
      end else begin
         if (!b_valid || grant_b)
            starve_cnt <= '0;
         else if (starve_cnt != LIM)
            starve_cnt <= starve_cnt + SW'(1);
         rd_pending <= grant_b && !b_we;
         if (rd_pending)
            held_rdata <= mem_rdata;
         if (a_stall && (stall_count != '1))
            stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench: three arbiter configurations share one stimulus stream, each
// checked against a cycle-level model of the arbitration rules.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_valid, b_we;
   logic [11:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;

   logic        a_stall_o [3];
   logic        b_ready_o [3];
   logic        b_rvalid_o[3];
   logic        mem_we_o  [3];
   logic [11:0] mem_addr_o[3];
   logic [31:0] mem_wd_o  [3];
   logic [31:0] a_rdata_o [3];
   logic [31:0] b_rdata_o [3];
   logic [15:0] sc_o      [3];

   int lim[3] = '{4, 0, 1};
   int cw [3] = '{16, 16, 4};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen
      localparam int LIM = (g == 0) ? 4 : ((g == 1) ? 0 : 1);
      localparam int CW  = (g == 2) ? 4 : 16;
      logic [CW-1:0] sc;
      logic [31:0]   mrd;
      logic [31:0]   mem [int];
      logic [31:0]   rd;

      dmem_port_arbiter #(.STARVE_LIMIT(LIM), .STALL_CNT_W(CW)) dut (
         .clk        (clk),
         .rst        (rst),
         .a_req      (a_req),
         .a_we       (a_we),
         .a_addr     (a_addr),
         .a_wdata    (a_wdata),
         .a_stall    (a_stall_o[g]),
         .a_rdata    (a_rdata_o[g]),
         .b_valid    (b_valid),
         .b_ready    (b_ready_o[g]),
         .b_we       (b_we),
         .b_addr     (b_addr),
         .b_wdata    (b_wdata),
         .b_rvalid   (b_rvalid_o[g]),
         .b_rdata    (b_rdata_o[g]),
         .mem_addr   (mem_addr_o[g]),
         .mem_we     (mem_we_o[g]),
         .mem_wdata  (mem_wd_o[g]),
         .mem_rdata  (mrd),
         .stall_count(sc)
      );

      assign sc_o[g] = 16'(sc);

      // single-port RAM, read-old, one-cycle registered read
      always @(posedge clk) begin
         rd = mem.exists(int'(mem_addr_o[g])) ? mem[int'(mem_addr_o[g])] : 32'h0;
         mrd <= rd;
         if (mem_we_o[g]) mem[int'(mem_addr_o[g])] = mem_wd_o[g];
      end
   end

   // reference model state
   int          starve[3];
   int          stalls[3];
   bit          pend  [3];
   bit          av    [3];
   logic [31:0] pendv [3];
   logic [31:0] held  [3];
   logic [31:0] aval  [3];
   logic [31:0] mm    [int];

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [31:0] rdm(int k, logic [11:0] a);
      int key = k * 4096 + int'(a);
      return mm.exists(key) ? mm[key] : 32'h0;
   endfunction

   function automatic bit gnt(int k);
      bit frc = (lim[k] != 0) && (starve[k] >= lim[k]);
      return !rst && b_valid && (!a_req || frc);
   endfunction

   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[cfg%0d] observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         bit gb = gnt(k);
         bit we = gb ? b_we : (!rst && a_req && a_we);
         bit rv = pend[k] && !rst;
         chk("b_ready", k, 32'(b_ready_o[k]), 32'(gb));
         chk("a_stall", k, 32'(a_stall_o[k]), 32'(a_req && gb));
         chk("mem_we", k, 32'(mem_we_o[k]), 32'(we));
         chk("mem_addr", k, 32'(mem_addr_o[k]), 32'(gb ? b_addr : a_addr));
         if (we)
            chk("mem_wdata", k, mem_wd_o[k], gb ? b_wdata : a_wdata);
         chk("b_rvalid", k, 32'(b_rvalid_o[k]), 32'(rv));
         chk("b_rdata", k, b_rdata_o[k], rv ? pendv[k] : held[k]);
         if (av[k])
            chk("a_rdata", k, a_rdata_o[k], aval[k]);
         chk("stall_count", k, 32'(sc_o[k]), 32'(stalls[k]));
      end
   endtask

   task automatic update_model();
      for (int k = 0; k < 3; k++) begin
         bit gb = gnt(k);
         if (rst) begin
            starve[k] = 0;
            stalls[k] = 0;
            pend[k]   = 0;
            held[k]   = 0;
            av[k]     = 0;
         end else begin
            if (pend[k]) held[k] = pendv[k];
            pend[k] = gb && !b_we;
            if (pend[k]) pendv[k] = rdm(k, b_addr);
            av[k] = a_req && !a_we && !gb;
            if (av[k]) aval[k] = rdm(k, a_addr);
            if (!b_valid || gb) starve[k] = 0;
            else if (starve[k] < lim[k]) starve[k]++;
            if (a_req && gb && stalls[k] < (1 << cw[k]) - 1) stalls[k]++;
            if (gb && b_we) mm[k * 4096 + int'(b_addr)] = b_wdata;
            else if (!gb && a_req && a_we) mm[k * 4096 + int'(a_addr)] = a_wdata;
         end
      end
   endtask

   task automatic step();
      #5;
      check_all();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic idle();
      a_req = 0; a_we = 0; b_valid = 0; b_we = 0;
   endtask

   initial begin
      rst = 1; idle();
      a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
      @(posedge clk);
      #1;
      step();
      step();
      rst = 0;
      step();

      // A only: store then load
      a_req = 1; a_we = 1; a_addr = 12'h010; a_wdata = 32'hDEADBEEF;
      step();
      a_we = 0;
      step();
      idle();
      step();
      chk("a_rdata_direct", 0, a_rdata_o[0], 32'hDEADBEEF);

      // B only: write then read, response held afterwards
      b_valid = 1; b_we = 1; b_addr = 12'h020; b_wdata = 32'h12345678;
      step();
      b_we = 0;
      step();
      idle();
      step();
      step();
      chk("b_rdata_held", 0, b_rdata_o[0], 32'h12345678);

      // sustained contention: forced grants and counter saturation
      a_req = 1; a_addr = 12'h020; b_valid = 1; b_we = 1;
      b_addr = 12'h020; b_wdata = 32'hCAFE0001;
      for (int i = 0; i < 100; i++) step();
      chk("sat_stall_cnt", 2, 32'(sc_o[2]), 32'd15);
      chk("nolimit_stall_cnt", 1, 32'(sc_o[1]), 32'd0);
      a_req = 0;
      step();
      idle();
      step();

      // B read handshake immediately followed by reset
      b_valid = 1; b_addr = 12'h020;
      step();
      idle(); rst = 1;
      step();
      rst = 0;
      step();
      chk("rst_b_rdata", 0, b_rdata_o[0], 32'h0);

      // randomized traffic over a small address window
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 79) == 0);
         a_req   = ($urandom_range(0, 2) != 0);
         a_we    = $urandom_range(0, 1) == 1;
         a_addr  = 12'($urandom_range(0, 7));
         a_wdata = $urandom;
         b_valid = ($urandom_range(0, 2) != 0);
         b_we    = $urandom_range(0, 1) == 1;
         b_addr  = 12'($urandom_range(0, 7));
         b_wdata = $urandom;
         step();
      end
      rst = 0; idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port synchronous data memory (12-bit word address, 32-bit data, 1-cycle read latency) between two requesters. Port A is the pipeline MEM stage (load/store) and has priority. Port B is a loader/debug master with a valid/ready handshake. A starvation counter lets B force a grant and stall the pipeline for one cycle. The block sits between the MEM stage, the data memory instance and the debug/loader logic.

Parameters:
STARVE_LIMIT, 8, consecutive cycles B may wait before it forces a grant; 0 means B never forces.
STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
a_req  in  1  MEM stage has a load or store this cycle
a_we  in  1  A access is a store
a_addr  in  12  A word address
a_wdata  in  32  A store data
a_stall  out  1  A access not performed; the pipeline must hold and re-present it next cycle
a_rdata  out  32  read data for A (valid the cycle after an unstalled A read)
b_valid  in  1  B request valid
b_ready  out  1  B request accepted this cycle
b_we  in  1  B access is a write
b_addr  in  12  B word address
b_wdata  in  32  B write data
b_rvalid  out  1  B read data valid pulse
b_rdata  out  32  B read data
mem_addr  out  12  memory address
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, registered inside the memory, 1-cycle latency
stall_count  out  STALL_CNT_W  saturating count of cycles with a_stall=1

Behaviour:
- Reset (rst=1 at posedge):
  - starve_cnt=0, b_rvalid=0, held read data=0, stall_count=0, rd_pending=0.
  - While rst=1, the combinational outputs are forced: b_ready=0, a_stall=0, mem_we=0.
- Grant, combinational each cycle:
  - force_b = (STARVE_LIMIT!=0) && starve_cnt>=STARVE_LIMIT.
  - grant_b = b_valid && (!a_req || force_b).
  - b_ready = grant_b.
  - a_stall = a_req && grant_b.
- Memory mux:
  - grant_b selects B's addr, we and wdata; otherwise A's are driven.
  - mem_we = grant_b ? b_we : (a_req && a_we).
  - No grant (idle): mem_addr = a_addr, mem_we = 0.
- a_rdata = mem_rdata, pass-through, no register.
- starve_cnt:
  - Cleared on a B handshake (b_valid && b_ready) or when b_valid=0.
  - Incremented when b_valid && !b_ready.
  - Saturates at STARVE_LIMIT.
  - Result: after STARVE_LIMIT refused cycles, the next cycle grants B.
- B read response:
  - rd_pending is set the cycle after a B read handshake (b_we=0).
  - b_rvalid = rd_pending, so it is exactly a 1-cycle pulse at T+1.
  - While b_rvalid=1, b_rdata = mem_rdata and mem_rdata is captured into the held register.
  - Otherwise b_rdata = held register; it stays stable until the next response.
  - B writes produce no response.
  - Back-to-back B reads give back-to-back b_rvalid pulses; throughput is 1 per cycle.
- stall_count increments on every cycle with a_stall=1 and holds at all-ones.
- Simultaneous events:
  - Same-cycle A and B to the same address: only B is performed; A repeats next cycle and sees B's write.
  - A B write followed next cycle by an A read of the same address returns the new data (the memory is write-then-read ordered across cycles).
- Reset mid-operation: a B read handshaken in the cycle before rst produces no b_rvalid; starve_cnt and stall_count clear.

Test Plan:
- A only: a_req=1, a_we=1, addr=0x010, data=0xDEADBEEF, then a read of 0x010 -> a_stall=0 throughout; a_rdata=0xDEADBEEF one cycle after the read.
- B only: b_valid=1, write 0x020=0x12345678, then read 0x020 -> b_ready=1 both cycles; b_rvalid pulses one cycle after the read with b_rdata=0x12345678, held after the pulse.
- Contention, STARVE_LIMIT=4: a_req=1 every cycle, b_valid=1 from cycle 0 -> b_ready=0 in cycles 0-3, b_ready=1 and a_stall=1 in cycle 4, starve_cnt back to 0, stall_count=1.
- STARVE_LIMIT=0: a_req=1 for 100 cycles with b_valid=1 -> b_ready never 1, a_stall never 1; b_ready rises the first cycle a_req=0.
- Reset mid-read: B read handshake at cycle N, rst=1 at cycle N+1 -> b_rvalid=0 in N+1; stall_count=0 and b_rdata=0 afterwards.
- Saturation, STALL_CNT_W=4, STARVE_LIMIT=1: sustained contention -> stall_count stops at 15 and stays there.
